// File: rtl/cpu_io_port_if.sv
// rtl/cpu_io_port_if.sv - CPU-side OUT/IN request/acknowledge bus for cpu_io_port
interface cpu_io_port_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             we;
  logic [7:0]       port;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;

  modport master (output req, we, port, wdata, input ack, rdata);
  modport slave  (input req, we, port, wdata, output ack, rdata);
endinterface

// File: rtl/cpu_io_port.sv
// rtl/cpu_io_port.sv - OUT/IN port unit with synchronized input pins
// Optional rising-edge sticky flags on ports NPORTS..2*NPORTS-1: CPU_IO_PORT_EDGE_LATCH_EN
module cpu_io_port #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cpu_io_port_if.slave            bus,
  output logic [NPORTS*WIDTH-1:0] pout,
  output logic [NPORTS-1:0]       pout_stb,
  input  logic [NPORTS*WIDTH-1:0] pin
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t                  state, state_d;
  logic                    wr_go, rd_go;
  logic [7:0]              port_q;
  logic [NPORTS*WIDTH-1:0] pin_m, pin_s;
  logic [WIDTH-1:0]        rd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_m <= '0;
      pin_s <= '0;
    end else begin
      pin_m <= pin;
      pin_s <= pin_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // WAIT holds until req drops so a req held across ack cannot re-execute
  always_comb begin
    state_d = state;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.we) begin
            wr_go   = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rd_go   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CPU_IO_PORT_EDGE_LATCH_EN
  logic [NPORTS*WIDTH-1:0] pin_d, flags, clr;

  // New edges are ORed in after the clear, so an edge coincident with the read survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_d <= '0;
      flags <= '0;
    end else begin
      pin_d <= pin_s;
      flags <= (flags & ~clr) | (pin_s & ~pin_d);
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_q == 8'(p)) rd_val = pin_s[p*WIDTH +: WIDTH];
    end
`ifdef CPU_IO_PORT_EDGE_LATCH_EN
    clr = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_q == 8'(NPORTS + p)) begin
        rd_val = flags[p*WIDTH +: WIDTH];
        if (rd_go) clr[p*WIDTH +: WIDTH] = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      pout      <= '0;
      pout_stb  <= '0;
      port_q    <= '0;
    end else begin
      bus.ack  <= wr_go | rd_go;
      pout_stb <= '0;
      if (wr_go) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (bus.port == 8'(p)) begin
            pout[p*WIDTH +: WIDTH] <= bus.wdata;
            pout_stb[p]            <= 1'b1;
          end
        end
      end
      if (state == IDLE && bus.req && !bus.we) port_q <= bus.port;
      if (rd_go) bus.rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_cpu_io_port.sv
// tb/tb_cpu_io_port.sv - directed self-checking bench for cpu_io_port
module tb_cpu_io_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pout;
  logic [3:0]  pout_stb;
  logic [31:0] pin;
  int          n_chk  = 0;
  int          n_pass = 0;

  cpu_io_port_if #(.WIDTH(8)) bus ();

  cpu_io_port #(.NPORTS(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pout     (pout),
    .pout_stb (pout_stb),
    .pin      (pin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from req to ack (0 if no ack within bound) plus values seen in the ack cycle
  task automatic xfer(input logic w, input logic [7:0] p, input logic [7:0] d,
                      output logic [7:0] rd, output logic [3:0] stb,
                      output logic [31:0] po, output int cyc);
    bus.req = 1'b1; bus.we = w; bus.port = p; bus.wdata = d;
    cyc = 0; rd = '0; stb = '0; po = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.ack === 1'b1) begin
        cyc = i; rd = bus.rdata; stb = pout_stb; po = pout;
        break;
      end
    end
    bus.req = 1'b0;
    tick();
  endtask

  logic [7:0]  rd;
  logic [3:0]  stb;
  logic [31:0] po;
  int          cyc;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.port = '0; bus.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      pin = $urandom;
      tick();
    end
    n_chk++; if (bus.ack !== 1'b0) $display("FAIL reset_ack got %b want 0", bus.ack); else n_pass++;
    n_chk++; if (bus.rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", bus.rdata); else n_pass++;
    n_chk++; if (pout !== 32'h0) $display("FAIL reset_pout got %h want 0", pout); else n_pass++;
    n_chk++; if (pout_stb !== 4'h0) $display("FAIL reset_stb got %b want 0000", pout_stb); else n_pass++;
    pin = 32'h0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    xfer(1'b0, 8'd0, 8'h00, rd, stb, po, cyc);
    n_chk++; if (cyc !== 2) $display("FAIL reset_read_lat got %0d want 2", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h00) $display("FAIL reset_read_data got %h want 00", rd); else n_pass++;
  endtask

  task automatic test_write();
    xfer(1'b1, 8'd2, 8'hA5, rd, stb, po, cyc);
    n_chk++; if (cyc !== 1) $display("FAIL write_lat got %0d want 1", cyc); else n_pass++;
    n_chk++; if (stb !== 4'b0100) $display("FAIL write_stb got %b want 0100", stb); else n_pass++;
    n_chk++; if (po !== 32'h00A5_0000) $display("FAIL write_pout got %h want 00a50000", po); else n_pass++;
    n_chk++; if (pout_stb !== 4'h0) $display("FAIL write_stb_drop got %b want 0000", pout_stb); else n_pass++;
    n_chk++; if (bus.ack !== 1'b0) $display("FAIL write_ack_drop got %b want 0", bus.ack); else n_pass++;
  endtask

  task automatic test_read();
    pin = 32'h0000_3C00;
    tick(); tick();
    xfer(1'b0, 8'd1, 8'h00, rd, stb, po, cyc);
    n_chk++; if (cyc !== 2) $display("FAIL read_lat got %0d want 2", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h3C) $display("FAIL read_p1 got %h want 3c", rd); else n_pass++;
    n_chk++; if (bus.rdata !== 8'h3C) $display("FAIL read_hold got %h want 3c", bus.rdata); else n_pass++;
    n_chk++; if (bus.ack !== 1'b0) $display("FAIL read_ack_drop got %b want 0", bus.ack); else n_pass++;
    pin = 32'h1122_3344;
    tick(); tick();
    xfer(1'b0, 8'd3, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h11) $display("FAIL read_p3 got %h want 11", rd); else n_pass++;
    xfer(1'b0, 8'd0, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h44) $display("FAIL read_p0 got %h want 44", rd); else n_pass++;
  endtask

  task automatic test_held_req();
    int acks, stbs;
    acks = 0; stbs = 0;
    bus.req = 1'b1; bus.we = 1'b1; bus.port = 8'd0; bus.wdata = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ack === 1'b1) acks++;
      if (pout_stb[0] === 1'b1) stbs++;
    end
    bus.req = 1'b0;
    tick();
    n_chk++; if (acks !== 1) $display("FAIL held_acks got %0d want 1", acks); else n_pass++;
    n_chk++; if (stbs !== 1) $display("FAIL held_stbs got %0d want 1", stbs); else n_pass++;
    n_chk++; if (pout !== 32'h00A5_0001) $display("FAIL held_pout got %h want 00a50001", pout); else n_pass++;
  endtask

  task automatic test_out_of_range();
    xfer(1'b1, 8'd9, 8'hFF, rd, stb, po, cyc);
    n_chk++; if (cyc !== 1) $display("FAIL oor_wr_ack got %0d want 1", cyc); else n_pass++;
    n_chk++; if (stb !== 4'h0) $display("FAIL oor_wr_stb got %b want 0000", stb); else n_pass++;
    n_chk++; if (po !== 32'h00A5_0001) $display("FAIL oor_wr_pout got %h want 00a50001", po); else n_pass++;
    xfer(1'b0, 8'd9, 8'h00, rd, stb, po, cyc);
    n_chk++; if (cyc !== 2) $display("FAIL oor_rd_lat got %0d want 2", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h00) $display("FAIL oor_rd_p9 got %h want 00", rd); else n_pass++;
    xfer(1'b1, 8'd4, 8'h77, rd, stb, po, cyc);
    n_chk++; if (stb !== 4'h0 || po !== 32'h00A5_0001)
      $display("FAIL oor_wr_p4 got stb=%b pout=%h want stb=0000 pout=00a50001", stb, po); else n_pass++;
`ifndef CPU_IO_PORT_EDGE_LATCH_EN
    xfer(1'b0, 8'd4, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h00) $display("FAIL oor_rd_p4 got %h want 00", rd); else n_pass++;
`endif
  endtask

`ifdef CPU_IO_PORT_EDGE_LATCH_EN
  task automatic test_edge_latch();
    pin = 32'h0;
    tick(); tick(); tick();
    for (int p = 4; p < 8; p++) xfer(1'b0, 8'(p), 8'h00, rd, stb, po, cyc);
    pin = 32'h0000_0008;
    tick();
    pin = 32'h0;
    tick(); tick(); tick();
    xfer(1'b0, 8'd4, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h08) $display("FAIL edge_bit3 got %h want 08", rd); else n_pass++;
    xfer(1'b0, 8'd4, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h00) $display("FAIL edge_clear got %h want 00", rd); else n_pass++;
    pin = 32'h0000_0001;
    tick();
    xfer(1'b0, 8'd4, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h00) $display("FAIL edge_coincide_rd got %h want 00", rd); else n_pass++;
    xfer(1'b0, 8'd4, 8'h00, rd, stb, po, cyc);
    n_chk++; if (rd !== 8'h01) $display("FAIL edge_set_wins got %h want 01", rd); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_read();
    pin = 32'h0000_005A;
    tick(); tick();
    bus.req = 1'b1; bus.we = 1'b0; bus.port = 8'd0;
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ack !== 1'b0) $display("FAIL midrst_ack got %b want 0", bus.ack); else n_pass++;
    tick();
    n_chk++; if (bus.ack !== 1'b0) $display("FAIL midrst_ack2 got %b want 0", bus.ack); else n_pass++;
    n_chk++; if (bus.rdata !== 8'h00 || pout !== 32'h0)
      $display("FAIL midrst_regs got rdata=%h pout=%h want 00/0", bus.rdata, pout); else n_pass++;
    bus.req = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    xfer(1'b0, 8'd0, 8'h00, rd, stb, po, cyc);
    n_chk++; if (cyc !== 2) $display("FAIL midrst_reissue_lat got %0d want 2", cyc); else n_pass++;
    n_chk++; if (rd !== 8'h5A) $display("FAIL midrst_reissue_data got %h want 5a", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_req();
    test_out_of_range();
`ifdef CPU_IO_PORT_EDGE_LATCH_EN
    test_edge_latch();
`endif
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
